apb_uart_requester: RTL and testbench

APB requester (master) for the APB UART register slave. It converts a single-outstanding valid/ready command stream into compliant APB SETUP/ACCESS transfers, honours PREADY wait states, and returns read data and error status on a valid/ready response channel. It sits between firmware-model or bus-bridge logic and the UART's `PSELx`/`PENABLE`/`PWRITE`/`PADDR`/`PWDATA`/`PRDATA`/`PREADY`/`PSLVERR` pins.

---
 rtl/apb_uart_req_pkg.sv | 23 ++
 rtl/apb_uart_requester.sv | 144 ++++++++++++++
 tb/tb_apb_uart_requester.sv | 285 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/apb_uart_req_pkg.sv
// Shared types and defaults for the APB requester that drives the UART register slave.
`timescale 1ns/1ps
package apb_uart_req_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } apb_state_e;

  localparam int unsigned DEF_ADDR_W = 32;
  localparam int unsigned DEF_DATA_W = 32;
  localparam int unsigned TMO_CNT_W  = 16;

  // Response payload at the default data width (the requester builds the same
  // layout at its own DATA_W).
  typedef struct packed {
    logic [DEF_DATA_W-1:0] rdata;
    logic                  err;
    logic                  timeout;
  } apb_rsp_t;

endpackage

// File: rtl/apb_uart_requester.sv
// APB requester: turns one outstanding valid/ready command into an APB
// SETUP/ACCESS transfer, honours PREADY wait states, aborts on timeout and
// returns read data / error status on a held valid/ready response channel.
`timescale 1ns/1ps
module apb_uart_requester
  import apb_uart_req_pkg::*;
#(
  parameter int unsigned ADDR_W  = DEF_ADDR_W,
  parameter int unsigned DATA_W  = DEF_DATA_W,
  parameter int unsigned TIMEOUT = 256
) (
  input  logic              PCLK,
  input  logic              PRESET,
  // Command channel
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_wdata,
  // Response channel
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              rsp_timeout,
  // APB pins
  output logic              PSELx,
  output logic              PENABLE,
  output logic              PWRITE,
  output logic [ADDR_W-1:0] PADDR,
  output logic [DATA_W-1:0] PWDATA,
  input  logic [DATA_W-1:0] PRDATA,
  input  logic              PREADY,
  input  logic              PSLVERR,
  // Debug view of the transfer FSM
  output apb_state_e        dbg_state_o
);

  // Handshakes: a beat moves on the rising edge where valid and ready are both
  // high. A producer holds valid and its payload stable until that edge; ready
  // may change freely. rsp_valid stays high, payload unchanged, until drained.

  typedef struct packed {
    logic [DATA_W-1:0] rdata;
    logic              err;
    logic              timeout;
  } rsp_t;

  localparam bit                   TMO_EN   = (TIMEOUT != 0);
  localparam logic [TMO_CNT_W-1:0] TMO_LAST = TMO_EN ? TMO_CNT_W'(TIMEOUT - 1) : '0;

  apb_state_e           state_q;
  logic                 psel_q;
  logic                 penable_q;
  logic                 pwrite_q;
  logic [ADDR_W-1:0]    paddr_q;
  logic [DATA_W-1:0]    pwdata_q;
  logic [TMO_CNT_W-1:0] tmo_cnt_q;
  logic                 rsp_valid_q;
  rsp_t                 rsp_q;
  logic                 cmd_fire;

  // Single outstanding transfer: accept only from IDLE with the response slot
  // empty or being drained on this same edge.
  assign cmd_ready = (state_q == IDLE) && (!rsp_valid_q || rsp_ready);
  assign cmd_fire  = cmd_valid && cmd_ready;

  // Transfer FSM, timeout counter and response register.
  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      state_q     <= IDLE;
      psel_q      <= 1'b0;
      penable_q   <= 1'b0;
      pwrite_q    <= 1'b0;
      paddr_q     <= '0;
      pwdata_q    <= '0;
      tmo_cnt_q   <= '0;
      rsp_valid_q <= 1'b0;
      rsp_q       <= '0;
    end else begin
      if (rsp_valid_q && rsp_ready) begin
        rsp_valid_q <= 1'b0;
      end
      case (state_q)
        IDLE: begin
          if (cmd_fire) begin
            paddr_q   <= cmd_addr;
            pwrite_q  <= cmd_write;
            pwdata_q  <= cmd_write ? cmd_wdata : '0;
            psel_q    <= 1'b1;
            penable_q <= 1'b0;
            state_q   <= SETUP;
          end
        end
        SETUP: begin
          penable_q <= 1'b1;
          tmo_cnt_q <= '0;
          state_q   <= ACCESS;
        end
        ACCESS: begin
          if (PREADY) begin
            rsp_q.rdata   <= pwrite_q ? '0 : PRDATA;
            rsp_q.err     <= PSLVERR;
            rsp_q.timeout <= 1'b0;
            rsp_valid_q   <= 1'b1;
            psel_q        <= 1'b0;
            penable_q     <= 1'b0;
            state_q       <= IDLE;
          end else begin
            tmo_cnt_q <= tmo_cnt_q + 1'b1;
            // The counter holds the number of ACCESS cycles already spent, so
            // this fires at the end of the TIMEOUT-th unanswered ACCESS cycle.
            if (TMO_EN && (tmo_cnt_q == TMO_LAST)) begin
              rsp_q.rdata   <= '0;
              rsp_q.err     <= 1'b1;
              rsp_q.timeout <= 1'b1;
              rsp_valid_q   <= 1'b1;
              psel_q        <= 1'b0;
              penable_q     <= 1'b0;
              state_q       <= IDLE;
            end
          end
        end
        default: begin
          psel_q    <= 1'b0;
          penable_q <= 1'b0;
          state_q   <= IDLE;
        end
      endcase
    end
  end

  assign PSELx       = psel_q;
  assign PENABLE     = penable_q;
  assign PWRITE      = pwrite_q;
  assign PADDR       = paddr_q;
  assign PWDATA      = pwdata_q;
  assign rsp_valid   = rsp_valid_q;
  assign rsp_rdata   = rsp_q.rdata;
  assign rsp_err     = rsp_q.err;
  assign rsp_timeout = rsp_q.timeout;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_apb_uart_requester.sv
// Bench for apb_uart_requester: directed commands against a scripted APB
// slave, with a response scoreboard and a bus-phase checker.
`timescale 1ns/1ps
module tb_apb_uart_requester;
  import apb_uart_req_pkg::*;

  localparam int AW    = 32;
  localparam int DW    = 32;
  localparam int TMO   = 4;
  localparam int RSP_W = $bits(apb_rsp_t);

  // ---------------- clock / reset ----------------
  logic PCLK = 1'b0;
  logic PRESET;
  always #5 PCLK = ~PCLK;

  logic          cmd_valid, cmd_ready, cmd_write;
  logic [AW-1:0] cmd_addr;
  logic [DW-1:0] cmd_wdata;
  logic          rsp_valid, rsp_ready, rsp_err, rsp_timeout;
  logic [DW-1:0] rsp_rdata;
  logic          PSELx, PENABLE, PWRITE, PREADY, PSLVERR;
  logic [AW-1:0] PADDR;
  logic [DW-1:0] PWDATA, PRDATA;
  apb_state_e    dbg_state;

  apb_uart_requester #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TMO)) dut (
    .PCLK(PCLK), .PRESET(PRESET),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_err(rsp_err), .rsp_timeout(rsp_timeout),
    .PSELx(PSELx), .PENABLE(PENABLE), .PWRITE(PWRITE), .PADDR(PADDR),
    .PWDATA(PWDATA), .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR),
    .dbg_state_o(dbg_state)
  );

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  always @(posedge PCLK) cyc <= cyc + 1;

  // Scoreboard queues: expected response and the cycle it must first appear.
  logic [RSP_W-1:0] exp_q[$];
  int               exp_cyc_q[$];

  // Bus expectations for the transfer in flight.
  logic          exp_wr      = 1'b0;
  logic [AW-1:0] exp_addr    = '0;
  logic [DW-1:0] exp_wdata   = '0;
  int            exp_sel_len = -1;

  // Slave script: waits < 0 means PREADY never rises.
  int            slv_waits    = 0;
  logic [DW-1:0] slv_rdata    = '0;
  logic          slv_err      = 1'b0;
  logic          slv_err_wait = 1'b0;
  int            drain_cyc    = -1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // ---------------- APB slave model ----------------
  int acc_n = 0;
  always @(negedge PCLK) begin
    if (PSELx && PENABLE) begin
      PREADY  = (slv_waits >= 0) && (acc_n == slv_waits);
      PSLVERR = PREADY ? slv_err : slv_err_wait;
      PRDATA  = PREADY ? slv_rdata : ~slv_rdata;
      acc_n++;
    end else begin
      // Spurious values outside ACCESS must be ignored by the requester.
      acc_n   = 0;
      PREADY  = 1'b1;
      PSLVERR = 1'b1;
      PRDATA  = 32'hDEAD_BEEF;
    end
  end

  // ---------------- bus-phase checker ----------------
  int sel_n = 0;
  always @(negedge PCLK) begin
    if (PSELx) begin
      check("paddr", 64'(PADDR), 64'(exp_addr));
      check("pwrite_pwdata", 64'({PWRITE, PWDATA}), 64'({exp_wr, exp_wdata}));
      check("penable", 64'(PENABLE), 64'(sel_n != 0));
      sel_n++;
    end else if (sel_n > 0) begin
      if (exp_sel_len >= 0) check("psel_len", 64'(sel_n), 64'(exp_sel_len));
      sel_n = 0;
    end
  end

  // ---------------- response monitor ----------------
  logic     seen = 1'b0;
  apb_rsp_t held;
  always @(negedge PCLK) begin
    logic [RSP_W-1:0] e;
    int               c;
    if (PRESET) begin
      seen = 1'b0;
    end else if (rsp_valid) begin
      if (!seen) begin
        seen = 1'b1;
        held = {rsp_rdata, rsp_err, rsp_timeout};
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_rsp: got=%0h want=none (cycle %0d)", held, cyc);
        end else begin
          e = exp_q.pop_front();
          c = exp_cyc_q.pop_front();
          check("rsp_fields", 64'(held), 64'(e));
          check("rsp_latency", 64'(cyc), 64'(c));
        end
      end else begin
        check("rsp_hold", 64'({rsp_rdata, rsp_err, rsp_timeout}), 64'(held));
      end
      if (rsp_ready) begin
        seen      = 1'b0;
        drain_cyc = cyc + 1;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic send(input logic wr, input logic [AW-1:0] addr, input logic [DW-1:0] wdata,
                      input int waits, input logic [DW-1:0] rdata, input logic err,
                      input logic err_wait, input bit will_reset, output int acc);
    int       n;
    apb_rsp_t e;
    slv_waits    = waits;
    slv_rdata    = rdata;
    slv_err      = err;
    slv_err_wait = err_wait;
    exp_wr       = wr;
    exp_addr     = addr;
    exp_wdata    = wr ? wdata : '0;
    exp_sel_len  = will_reset ? -1 : ((waits < 0) ? 1 + TMO : 2 + waits);
    @(posedge PCLK); #1;
    cmd_valid = 1'b1;
    cmd_write = wr;
    cmd_addr  = addr;
    cmd_wdata = wdata;
    n = 0;
    @(negedge PCLK);
    while (!cmd_ready && n < 50) begin
      n++;
      @(negedge PCLK);
    end
    acc = cyc + 1;
    if (!cmd_ready) begin
      total++;
      bad++;
      $display("FAIL cmd_accept_timeout: got=no_accept want=accept addr=%0h", addr);
    end else if (!will_reset) begin
      if (waits < 0) begin
        e.rdata = '0; e.err = 1'b1; e.timeout = 1'b1;
        exp_q.push_back(e);
        exp_cyc_q.push_back(acc + 1 + TMO);
      end else begin
        e.rdata = wr ? '0 : rdata; e.err = err; e.timeout = 1'b0;
        exp_q.push_back(e);
        exp_cyc_q.push_back(acc + 2 + waits);
      end
    end
    @(posedge PCLK); #1;
    cmd_valid = 1'b0;
  endtask

  task automatic wait_done(input string name);
    int n = 0;
    while ((exp_q.size() != 0 || rsp_valid) && n < 100) begin
      @(negedge PCLK);
      n++;
    end
    if (n >= 100) begin
      total++;
      bad++;
      $display("FAIL %s_done_timeout: got=pending want=drained", name);
    end
    @(posedge PCLK); #1;
  endtask

  task automatic check_reset_outputs(input string name);
    @(negedge PCLK);
    check({name, "_ctl"}, 64'({PSELx, PENABLE, PWRITE, cmd_ready, rsp_valid, rsp_err, rsp_timeout}),
          64'(7'b0001000));
    check({name, "_paddr"}, 64'(PADDR), 64'(0));
    check({name, "_pwdata"}, 64'(PWDATA), 64'(0));
    check({name, "_rdata"}, 64'(rsp_rdata), 64'(0));
    check({name, "_state"}, 64'(dbg_state), 64'(IDLE));
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int acc_a, acc_b;
    PRESET = 1'b1; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_wdata = '0;
    rsp_ready = 1'b1; PREADY = 1'b0; PSLVERR = 1'b0; PRDATA = '0;
    repeat (3) @(posedge PCLK);
    #1 PRESET = 1'b0;
    check_reset_outputs("reset");

    // zero-wait write, slave PRDATA must not leak into the response
    send(1'b1, 32'h0000_0008, 32'h0000_00A5, 0, 32'h0000_1234, 1'b0, 1'b0, 1'b0, acc_a);
    wait_done("wr0");
    // read with three wait states
    send(1'b0, 32'h0000_0004, 32'hFFFF_FFFF, 3, 32'h0000_005A, 1'b0, 1'b0, 1'b0, acc_a);
    wait_done("rd3");
    // slave error on completion
    send(1'b0, 32'h0000_0020, 32'h0000_FFFF, 0, 32'h0000_0BAD, 1'b1, 1'b0, 1'b0, acc_a);
    wait_done("err");
    // PSLVERR during wait states only: ignored
    send(1'b0, 32'h0000_0024, 32'h0, 2, 32'h0000_0077, 1'b0, 1'b1, 1'b0, acc_a);
    wait_done("errwait");
    // read timeout
    send(1'b0, 32'h0000_000C, 32'h0, -1, 32'h0000_0055, 1'b1, 1'b1, 1'b0, acc_a);
    wait_done("tmo_rd");
    check("tmo_psel", 64'(PSELx), 64'(0));
    // write timeout
    send(1'b1, 32'h0000_001C, 32'h0000_CAFE, -1, 32'h0000_0066, 1'b0, 1'b0, 1'b0, acc_a);
    wait_done("tmo_wr");

    // back-pressure: response held, next command waits for the drain edge
    rsp_ready = 1'b0;
    send(1'b0, 32'h0000_0010, 32'h0, 0, 32'h0000_0033, 1'b0, 1'b0, 1'b0, acc_a);
    begin
      int n = 0;
      @(negedge PCLK);
      while (!rsp_valid && n < 20) begin
        n++;
        @(negedge PCLK);
      end
      check("bp_rsp_arrived", 64'(rsp_valid), 64'(1));
    end
    @(posedge PCLK); #1;
    fork
      send(1'b1, 32'h0000_0014, 32'h0000_0099, 1, 32'h0, 1'b0, 1'b0, 1'b0, acc_b);
      begin
        repeat (4) begin
          @(negedge PCLK);
          check("bp_cmd_ready", 64'(cmd_ready), 64'(0));
          check("bp_rsp_valid", 64'(rsp_valid), 64'(1));
        end
        @(posedge PCLK); #1;
        rsp_ready = 1'b1;
      end
    join
    check("bp_same_edge", 64'(acc_b), 64'(drain_cyc));
    wait_done("bp");

    // reset during an ACCESS wait state
    send(1'b0, 32'h0000_0030, 32'h0, -1, 32'h0000_0011, 1'b0, 1'b0, 1'b1, acc_a);
    @(posedge PCLK);
    @(negedge PCLK);
    check("mid_state", 64'(dbg_state), 64'(ACCESS));
    @(posedge PCLK); #1;
    PRESET = 1'b1;
    @(posedge PCLK); #1;
    PRESET = 1'b0;
    check_reset_outputs("midrst");
    repeat (6) begin
      @(negedge PCLK);
      check("midrst_no_rsp", 64'(rsp_valid), 64'(0));
    end
    send(1'b0, 32'h0000_0018, 32'h0, 1, 32'h0000_00C3, 1'b0, 1'b0, 1'b0, acc_a);
    wait_done("post_rst");

    check("exp_q_empty", 64'(exp_q.size()), 64'(0));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got=running want=finished");
    $fatal(1, "watchdog");
  end

endmodule
